// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the gate truth-table checker:
// FSM state encoding, the settle-time floor and the expected-bit lookup.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MIN_SETTLE_CYCLES = 1;

  // Tables are zero-extended to 16 bits so one helper covers 1..4 inputs
  function automatic logic expected_bit(input logic [15:0] table_bits,
                                        input logic [3:0]  vec);
    return table_bits[vec];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// The zero flag marks the last settle cycle.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ZERO_VAL = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_VAL  = CW'(1'b1);

  logic [CW-1:0] r_count;

  // Count register: load has priority, and the counter parks at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= ZERO_VAL;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != ZERO_VAL)) begin
      r_count <= r_count - ONE_VAL;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == ZERO_VAL);

endmodule

// File: rtl/gate_truth_table_checker.sv
// On-chip exhaustive checker for a small combinational gate: walks every input
// vector, samples the gate after a settle delay and compares against EXPECTED.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int                        N_INPUTS      = 2,
  parameter logic [2**N_INPUTS-1:0]    EXPECTED      = 4'b0111,
  parameter int                        SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [N_INPUTS-1:0]   dut_inputs,
  input  logic                  dut_result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_INPUTS:0]     fail_count,
  output logic                  first_fail_valid,
  output logic [N_INPUTS-1:0]   first_fail_vector
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < MIN_SETTLE_CYCLES) ? MIN_SETTLE_CYCLES : SETTLE_CYCLES;
  localparam logic [N_INPUTS-1:0] MAX_VEC = {N_INPUTS{1'b1}};
  localparam logic [N_INPUTS-1:0] VEC_ONE = N_INPUTS'(1'b1);
  localparam logic [N_INPUTS:0]   FC_MAX  = {1'b1, {N_INPUTS{1'b0}}};
  localparam logic [N_INPUTS:0]   FC_ONE  = (N_INPUTS + 1)'(1'b1);
  localparam logic [15:0]         EXP16   = 16'(EXPECTED);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_INPUTS-1:0]   r_vector;
  logic [N_INPUTS:0]     r_fail_count;
  logic                  r_ffv;
  logic [N_INPUTS-1:0]   r_ffvec;
  logic                  r_pass;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_load;
  logic                  w_zero;
  logic                  w_last;
  logic                  w_mismatch;

  assign w_last     = (r_vector == MAX_VEC);
  assign w_mismatch = (dut_result != expected_bit(EXP16, 4'(r_vector)));

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_EFF)
  ) u_settle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_en    (r_state == SETTLE),
    .o_zero  (w_zero)
  );

  // Next-state decode; the timer reloads on every entry into SETTLE
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (w_zero) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      SAMPLE: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SETTLE;
          w_load      = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State plus busy/done, registered from the next state so they align with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Vector counter and result registers; the vector stops at MAX_VEC, never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vector     <= {N_INPUTS{1'b0}};
      r_fail_count <= {(N_INPUTS + 1){1'b0}};
      r_ffv        <= 1'b0;
      r_ffvec      <= {N_INPUTS{1'b0}};
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vector     <= {N_INPUTS{1'b0}};
            r_fail_count <= {(N_INPUTS + 1){1'b0}};
            r_ffv        <= 1'b0;
            r_ffvec      <= {N_INPUTS{1'b0}};
            r_pass       <= 1'b0;
          end
        end
        SAMPLE: begin
          if (w_mismatch) begin
            if (r_fail_count != FC_MAX) begin
              r_fail_count <= r_fail_count + FC_ONE;
            end
            if (!r_ffv) begin
              r_ffv   <= 1'b1;
              r_ffvec <= r_vector;
            end
          end
          if (!w_last) begin
            r_vector <= r_vector + VEC_ONE;
          end
        end
        DONE: begin
          r_pass <= (r_fail_count == {(N_INPUTS + 1){1'b0}});
        end
        default: begin
          r_vector <= r_vector;
        end
      endcase
    end
  end

  assign dut_inputs        = r_vector;
  assign busy              = r_busy;
  assign done              = r_done;
  assign pass              = r_pass;
  assign fail_count        = r_fail_count;
  assign first_fail_valid  = r_ffv;
  assign first_fail_vector = r_ffvec;

endmodule

// File: doc/gate_truth_table_checker.md
# gate_truth_table_checker

Synthesizable self-checking stimulus engine for small combinational gates. On `start` it walks every input vector of an N-input gate under test, holds each vector for a programmable settle time, samples the gate's single-bit `result`, and compares it against a parameterised expected truth table. It reports the failure count and the first failing vector. It sits beside the gate blocks (nand_gate and peers) as the on-chip counterpart to the simulation testbenches.

## Interface
Parameters:
- `N_INPUTS`, default 2: gate input count, 1..4.
- `EXPECTED`, default 4'b0111: expected truth table, width 2**N_INPUTS. Bit v is the expected `result` for input vector v (default = NAND).
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling, minimum 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a check run; sampled only in IDLE.
- `dut_inputs`  out  N_INPUTS  vector driven to the gate; bit 0 → input1, bit 1 → input2, ….
- `dut_result`  in  1  gate output.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  high when the last completed run had zero mismatches; held until the next accepted `start`.
- `fail_count`  out  N_INPUTS+1  mismatches in the current or last run, saturating at 2**N_INPUTS.
- `first_fail_valid`  out  1  at least one mismatch recorded this run.
- `first_fail_vector`  out  N_INPUTS  lowest failing vector; valid only with `first_fail_valid`.

## Operation
- Reset values: `dut_inputs`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_valid`=0, `first_fail_vector`=0. The FSM resets to IDLE.
- IDLE:
  - `start`=1 → vector←0, `fail_count`←0, `first_fail_valid`←0, `pass`←0, settle counter←SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - `dut_inputs`=vector.
  - Counter decrements each cycle.
  - At 0 → SAMPLE.
- SAMPLE:
  - Compare `dut_result` with `EXPECTED[vector]`.
  - On mismatch: `fail_count`++. If `first_fail_valid`=0, latch vector and set `first_fail_valid`.
  - If vector = 2**N_INPUTS-1 → DONE. Otherwise vector++, counter reloads, → SETTLE.
- DONE:
  - `done`=1 for this cycle only.
  - `pass` ← (final `fail_count`==0), including any mismatch in the last SAMPLE.
  - → IDLE.
- Other rules:
  - `start` during SETTLE, SAMPLE or DONE is ignored; there is no queuing.
  - The vector counter must not wrap. The exit decision uses an equality compare against the max vector before incrementing.
  - Reset asserted mid-run aborts immediately. All outputs take their reset values and no `done` is issued.
  - `dut_inputs` keeps the last vector after a run until the next `start` or reset.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- Cycle 1: `busy`=1 and `dut_inputs`=0.
- Each vector occupies SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- `done` pulses in cycle 1 + 2**N_INPUTS·(SETTLE_CYCLES+1). With the defaults this is cycle 21.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that same cycle.
- `dut_result` is sampled on the clock edge ending the SAMPLE cycle. The gate therefore sees the vector stable for SETTLE_CYCLES+1 edges.
- `fail_count`, `first_fail_*` and `pass` are registered. Updates are visible in the cycle after SAMPLE or DONE respectively.

## Structure
- Shared package `gate_check_pkg`:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - localparam for the minimum SETTLE_CYCLES (1).
  - function returning the expected bit for a given table and vector.
- One natural sub-module, `settle_timer`: a loadable down-counter with a zero flag, parameterised by SETTLE_CYCLES.
- The top-level holds the FSM, vector counter and result registers.

## Test plan
- Defaults, correct NAND connected, `start` pulse → `done` at cycle 21, `pass`=1, `fail_count`=0, `first_fail_valid`=0; `dut_inputs` sequences 0,1,2,3, each held 5 cycles.
- Defaults, AND gate connected instead → every vector mismatches: `fail_count`=4, `first_fail_vector`=0, `pass`=0.
- Defaults, NAND with input 2'b10 forced to 0 → `fail_count`=1, `first_fail_vector`=2, `pass`=0.
- `start` held high through the entire run → exactly one run; `start` still high in the IDLE cycle after `done` → second run begins and clears `fail_count` and `pass`.
- `reset_n` low at cycle 8 of a run → outputs return to reset values asynchronously; no `done` pulse; fresh `start` after release completes normally.
- N_INPUTS=3, EXPECTED=8'b1000_0000 (AND3), SETTLE_CYCLES=1 with correct AND3 → `done` at cycle 17, `pass`=1.
